// File: rtl/trackball_scan_ctrl.sv
// Time-multiplexed quadrature scanner: one shared decode/count datapath walks all
// trackball axes on each sample tick; the host reads counts through a req/ack port.
module trackball_scan_ctrl #(
  parameter int NAXES = 4,
  parameter int CNT_W = 7,
  parameter int DIV   = 64,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [NAXES-1:0] ina,
  input  logic [NAXES-1:0] inb,
  input  logic             rd_req,
  input  logic [SEL_W-1:0] rd_sel,
  input  logic             rd_clr,
  output logic             rd_ack,
  output logic [CNT_W-1:0] rd_data,
  output logic [NAXES-1:0] err,
  output logic             busy
);
  localparam int PW = $clog2(DIV);
  localparam int IW = $clog2(NAXES);

  generate
    if (DIV < NAXES + 4) begin : g_bad_div
      $error("trackball_scan_ctrl: DIV must be >= NAXES+4");
    end
    if (SEL_W < IW) begin : g_bad_sel
      $error("trackball_scan_ctrl: SEL_W must be >= clog2(NAXES)");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE, ST_SNAP, ST_SCAN, ST_READ} state_t;

  state_t                        state_q, state_d;
  logic [NAXES-1:0]              sync_a1_q, sync_a1_d, sync_a2_q, sync_a2_d;
  logic [NAXES-1:0]              sync_b1_q, sync_b1_d, sync_b2_q, sync_b2_d;
  logic [NAXES-1:0]              snap_a_q, snap_a_d, snap_b_q, snap_b_d;
  logic [NAXES-1:0]              prev_a_q, prev_a_d, prev_b_q, prev_b_d;
  logic [NAXES-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [NAXES-1:0]              err_q, err_d;
  logic [PW-1:0]                 presc_q, presc_d;
  logic                          tick_pend_q, tick_pend_d;
  logic                          rd_pend_q, rd_pend_d;
  logic [SEL_W-1:0]              sel_q, sel_d;
  logic                          clr_q, clr_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic                          busy_q, busy_d;
  logic                          rd_ack_q, rd_ack_d;
  logic [CNT_W-1:0]              rd_data_q, rd_data_d;

  logic          tick;
  logic          sel_ok;
  logic [IW-1:0] sel_idx;
  logic          ch_a, ch_b, plus;

  assign tick    = (presc_q == PW'(DIV - 1));
  assign sel_ok  = (int'(sel_q) < NAXES);
  assign sel_idx = sel_q[IW-1:0];

  always_comb begin
    state_d     = state_q;
    sync_a1_d   = ina;
    sync_a2_d   = sync_a1_q;
    sync_b1_d   = inb;
    sync_b2_d   = sync_b1_q;
    snap_a_d    = snap_a_q;
    snap_b_d    = snap_b_q;
    prev_a_d    = prev_a_q;
    prev_b_d    = prev_b_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    presc_d     = tick ? '0 : presc_q + PW'(1);
    tick_pend_d = tick_pend_q;
    rd_pend_d   = rd_pend_q;
    sel_d       = sel_q;
    clr_d       = clr_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    rd_ack_d    = 1'b0;
    rd_data_d   = rd_data_q;
    ch_a        = 1'b0;
    ch_b        = 1'b0;
    plus        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Reads win over a waiting tick; the ack cycle is the READ state itself.
        if (rd_pend_q) begin
          state_d   = ST_READ;
          rd_ack_d  = 1'b1;
          rd_pend_d = 1'b0;
          rd_data_d = sel_ok ? cnt_q[sel_idx] : '0;
          if (sel_ok && clr_q) begin
            cnt_d[sel_idx] = '0;
            err_d[sel_idx] = 1'b0;
          end
        end else if (tick_pend_q) begin
          state_d = ST_SNAP;
          busy_d  = 1'b1;
        end
      end
      ST_SNAP: begin
        snap_a_d    = sync_a2_q;
        snap_b_d    = sync_b2_q;
        tick_pend_d = 1'b0;
        idx_d       = '0;
        state_d     = ST_SCAN;
      end
      ST_SCAN: begin
        ch_a = snap_a_q[idx_q] ^ prev_a_q[idx_q];
        ch_b = snap_b_q[idx_q] ^ prev_b_q[idx_q];
        plus = (ch_a && (snap_a_q[idx_q] != snap_b_q[idx_q])) ||
               (ch_b && (snap_a_q[idx_q] == snap_b_q[idx_q]));
        if (ch_a && ch_b) begin
          err_d[idx_q] = 1'b1;
        end else if (ch_a || ch_b) begin
          cnt_d[idx_q] = plus ? cnt_q[idx_q] + CNT_W'(1) : cnt_q[idx_q] - CNT_W'(1);
        end
        prev_a_d[idx_q] = snap_a_q[idx_q];
        prev_b_d[idx_q] = snap_b_q[idx_q];
        if (int'(idx_q) == NAXES - 1) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_READ: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // New events are applied last so they win over the clears above.
    if (tick) tick_pend_d = 1'b1;
    if (rd_req) begin
      rd_pend_d = 1'b1;
      sel_d     = rd_sel;
      clr_d     = rd_clr;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= ST_IDLE;
      sync_a1_q   <= '0;
      sync_a2_q   <= '0;
      sync_b1_q   <= '0;
      sync_b2_q   <= '0;
      snap_a_q    <= '0;
      snap_b_q    <= '0;
      prev_a_q    <= '0;
      prev_b_q    <= '0;
      cnt_q       <= '0;
      err_q       <= '0;
      presc_q     <= '0;
      tick_pend_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      sel_q       <= '0;
      clr_q       <= 1'b0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      sync_a1_q   <= sync_a1_d;
      sync_a2_q   <= sync_a2_d;
      sync_b1_q   <= sync_b1_d;
      sync_b2_q   <= sync_b2_d;
      snap_a_q    <= snap_a_d;
      snap_b_q    <= snap_b_d;
      prev_a_q    <= prev_a_d;
      prev_b_q    <= prev_b_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      presc_q     <= presc_d;
      tick_pend_q <= tick_pend_d;
      rd_pend_q   <= rd_pend_d;
      sel_q       <= sel_d;
      clr_q       <= clr_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      rd_ack_q    <= rd_ack_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rd_ack  = rd_ack_q;
  assign rd_data = rd_data_q;
  assign err     = err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_trackball_scan_ctrl.sv
// Bench for trackball_scan_ctrl: Gray-position reference model updated once per
// completed scan, read/err/busy checks every cycle, plus directed literal checks.
module tb_trackball_scan_ctrl;
  localparam int NAXES = 4;
  localparam int CNT_W = 7;
  localparam int DIV   = 64;
  localparam int SEL_W = 3;
  localparam int CMOD  = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             clrn = 1'b0;
  logic [NAXES-1:0] ina = '0;
  logic [NAXES-1:0] inb = '0;
  logic             rd_req = 1'b0;
  logic [SEL_W-1:0] rd_sel = '0;
  logic             rd_clr = 1'b0;
  logic             rd_ack;
  logic [CNT_W-1:0] rd_data;
  logic [NAXES-1:0] err;
  logic             busy;

  always #5 clk = ~clk;

  trackball_scan_ctrl #(.NAXES(NAXES), .CNT_W(CNT_W), .DIV(DIV), .SEL_W(SEL_W)) dut (
    .clk(clk), .clrn(clrn), .ina(ina), .inb(inb), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_clr(rd_clr), .rd_ack(rd_ack), .rd_data(rd_data), .err(err), .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  int       m_cnt[NAXES];
  bit       m_err[NAXES];
  bit [1:0] m_prev[NAXES];
  bit       m_pend;
  int       m_sel;
  bit       m_clr;
  int       m_data;
  bit       prev_busy, prev_ack;
  int       busy_run;
  int       scan_cnt = 0;
  int       ack_cnt = 0;
  int       last_ack_data;
  int       pos[NAXES];

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Position along the forward quadrature cycle AB = 00,10,11,01.
  function automatic int gpos(bit [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic bit [1:0] ab_of(int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NAXES; i++) begin
      m_cnt[i] = 0; m_err[i] = 0; m_prev[i] = 2'b00;
    end
    m_pend = 0; m_sel = 0; m_clr = 0; m_data = 0;
    prev_busy = 0; prev_ack = 0; busy_run = 0;
  endtask

  function automatic int m_err_vec();
    int e = 0;
    for (int i = 0; i < NAXES; i++) if (m_err[i]) e |= (1 << i);
    return e;
  endfunction

  task automatic model_scan();
    bit [1:0] cur;
    int d;
    for (int i = 0; i < NAXES; i++) begin
      cur = {ina[i], inb[i]};
      d = (gpos(cur) - gpos(m_prev[i]) + 4) % 4;
      if (d == 1)      m_cnt[i] = (m_cnt[i] + 1) % CMOD;
      else if (d == 3) m_cnt[i] = (m_cnt[i] + CMOD - 1) % CMOD;
      else if (d == 2) m_err[i] = 1;
      m_prev[i] = cur;
    end
  endtask

  // Compare process: inputs captured at the edge, outputs checked mid-cycle.
  initial begin : monitor
    bit req_s, clr_s;
    int sel_s, exp;
    forever begin
      @(posedge clk);
      req_s = rd_req; sel_s = int'(rd_sel); clr_s = rd_clr;
      @(negedge clk);
      if (!clrn) begin
        model_reset();
      end else begin
        if (rd_ack) begin
          ack_cnt++;
          check("ack_pending", int'(m_pend), 1);
          check("ack_while_busy", int'(busy), 0);
          check("ack_single_cycle", int'(prev_ack), 0);
          exp = (m_sel < NAXES) ? m_cnt[m_sel] : 0;
          m_data = exp;
          if (m_clr && m_sel < NAXES) begin
            m_cnt[m_sel] = 0; m_err[m_sel] = 0;
          end
          m_pend = 0;
          last_ack_data = int'(rd_data);
        end
        check("rd_data", int'(rd_data), m_data);
        if (prev_busy && !busy) begin
          check("busy_len", busy_run, NAXES + 1);
          model_scan();
          scan_cnt++;
        end
        busy_run = busy ? busy_run + 1 : 0;
        if (!busy) check("err", int'(err), m_err_vec());
        prev_busy = busy;
        prev_ack  = rd_ack;
        if (req_s) begin
          m_pend = 1; m_sel = sel_s; m_clr = clr_s;
        end
      end
    end
  end

  // Returns two cycles after a scan finishes, well clear of the next sample point.
  task automatic wait_scan();
    int s = scan_cnt;
    int n = 0;
    while (scan_cnt == s && n < 4 * DIV) begin @(negedge clk); n++; end
    check("scan_timeout", int'(scan_cnt != s), 1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(int a, output int n);
    n = 1;
    while (ack_cnt == a && n < 4 * DIV) begin @(negedge clk); #1; n++; end
    check("ack_timeout", int'(ack_cnt != a), 1);
  endtask

  task automatic do_read(int sel, bit clr, bit fast, output int data);
    int a = ack_cnt;
    int n;
    @(negedge clk); #1;
    rd_req = 1; rd_sel = SEL_W'(sel); rd_clr = clr;
    @(negedge clk); #1;
    rd_req = 0;
    wait_ack(a, n);
    if (fast) check("rd_latency", n, 2);
    data = last_ack_data;
  endtask

  task automatic step(int ax, int dp);
    bit [1:0] ab;
    pos[ax] = (pos[ax] + dp) & 3;
    ab = ab_of(pos[ax]);
    ina[ax] = ab[1];
    inb[ax] = ab[0];
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int d, n, a;
    for (int i = 0; i < NAXES; i++) pos[i] = 0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack", int'(rd_ack), 0);
    check("rst_data", int'(rd_data), 0);
    check("rst_err", int'(err), 0);
    check("rst_busy", int'(busy), 0);
    #1 clrn = 1;
    n = 0;
    while (!busy && n < 4 * DIV) begin @(negedge clk); n++; end
    check("first_snap", n, DIV + 1);
    wait_scan();

    // Axis 0 forward one full cycle, then back, then one more step back
    for (int k = 0; k < 4; k++) begin step(0, 1); wait_scan(); end
    do_read(0, 0, 1, d); check("ax0_fwd4", d, 4);
    for (int k = 0; k < 4; k++) begin step(0, -1); wait_scan(); end
    do_read(0, 0, 1, d); check("ax0_back", d, 0);
    step(0, -1); wait_scan();
    do_read(0, 0, 1, d); check("ax0_underflow", d, 127);
    step(0, 1); wait_scan();

    // Axis 2 wraps after 128 forward steps
    for (int k = 0; k < 128; k++) begin step(2, 1); wait_scan(); end
    do_read(2, 0, 1, d); check("ax2_wrap", d, 0);
    check("ax2_no_err", int'(err), 0);

    // Illegal double change on axis 1
    step(1, 2); wait_scan();
    check("ax1_err_set", int'(err), 2);
    do_read(1, 1, 1, d); check("ax1_cnt_kept", d, 0);
    check("ax1_err_clr", int'(err), 0);

    // Read arriving during a scan, re-requested before it is served
    for (int k = 0; k < 3; k++) begin step(3, 1); wait_scan(); end
    n = 0;
    while (!busy && n < 2 * DIV) begin @(negedge clk); n++; end
    check("busy_timeout", int'(busy), 1);
    #1;
    a = ack_cnt;
    rd_req = 1; rd_sel = 3'd0; rd_clr = 0;
    @(negedge clk); #1;
    rd_sel = 3'd3; rd_clr = 1;
    @(negedge clk); #1;
    rd_req = 0;
    wait_ack(a, n);
    check("collide_data", last_ack_data, 3);
    repeat (4) @(negedge clk);
    check("collide_one_ack", ack_cnt - a, 1);
    do_read(3, 0, 1, d); check("collide_cleared", d, 0);
    wait_scan();

    // Select beyond the last axis
    do_read(5, 1, 1, d); check("bad_sel_data", d, 0);
    for (int i = 0; i < NAXES; i++) do_read(i, 0, 1, d);

    // Randomized motion and reads at arbitrary times
    for (int it = 0; it < 200; it++) begin
      int r;
      wait_scan();
      for (int i = 0; i < NAXES; i++) begin
        r = int'($urandom_range(0, 15));
        if (r < 5)       step(i, 1);
        else if (r < 9)  step(i, -1);
        else if (r == 9) step(i, 2);
      end
      if ($urandom_range(0, 2) != 0) begin
        repeat ($urandom_range(0, 60)) @(negedge clk);
        do_read(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0, d);
      end
    end

    // Reset in the middle of a scan
    n = 0;
    while (!busy && n < 2 * DIV) begin @(negedge clk); n++; end
    #1 clrn = 0;
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_ack", int'(rd_ack), 0);
    check("midrst_data", int'(rd_data), 0);
    #1 clrn = 1;
    wait_scan();
    for (int i = 0; i < NAXES; i++) do_read(i, 0, 1, d);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trackball_scan_ctrl.md
Name: trackball_scan_ctrl

Overview:
- Time-multiplexed trackball scanner for the JAMMA board.
- Shares one quadrature decode/up-down-count datapath across NAXES trackball axes. Each axis keeps its previous-phase state and count in small register arrays.
- Generates the sample cadence internally and scans all axes round-robin on every sample tick.
- Gives the host a request/acknowledge read port with optional read-and-clear.

Parameters:
- NAXES, 4, number of trackball axes (2..8).
- CNT_W, 7, width of each axis count.
- DIV, 64, clk cycles per sample tick. Must be ≥ NAXES+4; elaboration error otherwise.
- SEL_W, 2, width of rd_sel. Must be ≥ clog2(NAXES).

Ports:
- clk  in  1  system clock.
- clrn  in  1  asynchronous active-low reset.
- ina  in  NAXES  phase A, one bit per axis, asynchronous.
- inb  in  NAXES  phase B, one bit per axis, asynchronous.
- rd_req  in  1  single-cycle host read request.
- rd_sel  in  SEL_W  axis index, sampled with rd_req.
- rd_clr  in  1  clear the selected count and error flag after the read; sampled with rd_req.
- rd_ack  out  1  single-cycle pulse; rd_data is valid in the same cycle.
- rd_data  out  CNT_W  selected axis count.
- err  out  NAXES  sticky illegal-transition flags.
- busy  out  1  high while the scan is in progress.

Behaviour:
- Interface (already decided): reset clrn, asynchronous, active-low; clock clk.
- Reset state: all counts 0, prev-phase arrays 0, err 0, rd_ack 0, rd_data 0, busy 0, prescaler 0, FSM in IDLE, pending flags 0.
- Synchronisers: ina and inb each pass through a two-flop synchroniser that always runs.
- Prescaler:
  - Counts 0..DIV-1 and wraps.
  - At DIV-1, sets tick_pend.
- FSM states are IDLE, SNAP, SCAN, READ.
- IDLE:
  - If rd_pend is set, go to READ. Reads have priority over a pending tick.
  - Otherwise, if tick_pend is set, go to SNAP.
- SNAP: copy the synchronised A/B vectors into a snapshot register, so all axes are sampled coherently. Clear tick_pend, set idx=0, busy=1, go to SCAN.
- SCAN: one axis per cycle, idx = 0..NAXES-1. For axis i:
  - chA = snapA[i] xor prevA[i]; chB = snapB[i] xor prevB[i].
  - plus = (chA and snapA≠snapB) or (chB and snapA=snapB).
  - Only chA or only chB: count[i] ← count[i]+1 if plus, else −1. Arithmetic is modulo 2^CNT_W, so 2^CNT_W−1 +1 → 0 and 0 −1 → 2^CNT_W−1.
  - Both changed: count unchanged, err[i] ← 1.
  - Neither changed: count unchanged.
  - Then prev[i] ← snap[i].
  - After idx=NAXES-1, busy=0 and the FSM returns to IDLE.
  - Scan length is NAXES+1 cycles from SNAP to IDLE.
- Host read:
  - rd_req in any state latches rd_sel and rd_clr and sets rd_pend.
  - A second rd_req while rd_pend is set overwrites the latched sel/clr. Only one ack is produced.
  - A read that arrives during a scan is deferred until the scan returns to IDLE.
  - READ state: rd_data ← count[sel], rd_ack=1 for one cycle.
  - If clr is set, count[sel] ← 0 and err[sel] ← 0 in the same cycle. rd_data carries the pre-clear value.
  - READ clears rd_pend and returns to IDLE.
- rd_sel ≥ NAXES: rd_data=0, ack is still produced, no clear.
- rd_data holds its value until the next READ.
- Read latency is 2 cycles from rd_req when idle: latch cycle, then READ cycle with ack.
- A tick during READ or SCAN is held in tick_pend and never lost. A tick that arrives while tick_pend is already set is merged into it. DIV ≥ NAXES+4 guarantees no merge under normal reads.
- Reset mid-scan or mid-read aborts immediately to the reset state. No ack is issued.

Test Plan:
- Reset, DIV=64: hold clrn low → all outputs 0. Release → first SNAP at cycle 64. busy high for 5 cycles (NAXES=4).
- Axis 0 forward: A rises with B=0 on ticks, sequence AB 00→10→11→01→00 → count[0]=4. Reverse sequence → returns to 0, then 127 after one more reverse step.
- Wrap: 128 forward steps on axis 2 → count[2]=0. No err.
- Illegal: axis 1 AB 00→11 within one sample → err[1]=1, count[1] unchanged. Read with rd_clr → err[1]=0.
- Read collision: rd_req sel=3 clr=1 asserted during SCAN → ack only after busy falls. rd_data=old count. Next read returns 0. Tick pending at the same time → SNAP follows READ.
- Invalid select: rd_sel=5 with NAXES=4, SEL_W=3 → rd_ack pulse, rd_data=0, all counts unchanged.
